// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Purpose  : Instruction-fetch stage, producer side of the IF/ID register.
//            Owns the program counter and fetches from instruction memory
//            over a req/ack handshake. It handles hazard stalls,
//            branch/jump redirects and exception/interrupt vectoring,
//            including redirects that arrive while a request is in flight.
// Ports    : clk, reset       - clock (rising edge), synchronous active-high reset
//            stall            - hazard hold (IF/ID enable is ~stall)
//            redirect/_pc     - branch/jump taken and its target
//            exc, irq         - exception / interrupt requests
//            imem_req/addr    - memory request and word-aligned address
//            imem_ack/rdata   - memory response strobe and data
//            Instruction, PC, PC_plus_4, fetch_valid - IF/ID payload + qualifier
// Options  : KERNEL_BIT_KEEP_EN - the +4 increment keeps PC bit 31, and irq is
//            ignored while pc[31]=1.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc,
  input  logic        irq,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic [31:0] PC_plus_4,
  output logic        fetch_valid
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_buf;
  logic [31:0] w_buf_nxt;
  logic [31:0] r_tgt;
  logic [31:0] w_tgt_nxt;

  logic        w_irq_eff;
  logic        w_take;
  logic [31:0] w_target;
  logic [31:0] w_pc_inc;

`ifdef KERNEL_BIT_KEEP_EN
  // Supervisor bit is sticky across sequential fetch; interrupts are masked
  // while executing in supervisor space.
  assign w_pc_inc  = {r_pc[31], r_pc[30:0] + 31'd4};
  assign w_irq_eff = irq & ~r_pc[31];
`else
  assign w_pc_inc  = r_pc + 32'd4;
  assign w_irq_eff = irq;
`endif

  assign w_take   = exc | w_irq_eff | redirect;
  assign w_target = exc       ? ILLOP_PC :
                    w_irq_eff ? XADR_PC  :
                                redirect_pc;

  assign PC        = r_pc;
  assign PC_plus_4 = w_pc_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_buf   <= '0;
      r_tgt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_buf   <= w_buf_nxt;
      r_tgt   <= w_tgt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_buf_nxt   = r_buf;
    w_tgt_nxt   = r_tgt;
    imem_req    = 1'b0;
    imem_addr   = r_pc;
    Instruction = imem_rdata;
    fetch_valid = 1'b0;

    case (r_state)
      S_FETCH: begin
        imem_req    = 1'b1;
        fetch_valid = imem_ack & ~w_take;
        if (w_take && imem_ack) begin
          // Wrong-path word arrived together with the redirect: drop it.
          w_pc_nxt = w_target;
        end else if (w_take) begin
          // Request still in flight; it must complete at the old address
          // before the new target can be requested.
          w_tgt_nxt   = w_target;
          w_state_nxt = S_DISCARD;
        end else if (imem_ack && !stall) begin
          w_pc_nxt = w_pc_inc;
        end else if (imem_ack) begin
          // IF/ID is not loading this cycle, so keep the word locally.
          w_buf_nxt   = imem_rdata;
          w_state_nxt = S_HOLD;
        end
      end

      S_HOLD: begin
        Instruction = r_buf;
        fetch_valid = ~w_take;
        if (w_take) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_FETCH;
        end else if (!stall) begin
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_FETCH;
        end
      end

      S_DISCARD: begin
        imem_req = 1'b1;
        if (w_take) begin
          w_tgt_nxt = w_target;
        end
        if (imem_ack) begin
          w_pc_nxt    = w_take ? w_target : r_tgt;
          w_state_nxt = S_FETCH;
        end
      end

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase

    // Memory treats a dropped request as a cancel, so reset may abort one.
    if (reset) begin
      imem_req    = 1'b0;
      fetch_valid = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Purpose  : Self-checking bench for if_fetch_unit. A memory responder with
//            programmable latency plus an instruction-stream reference model
//            (expected next PC, liveness, handshake stability). Directed steps
//            are followed by a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

  localparam logic [31:0] C_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] C_ILLOP_PC = 32'h8000_0004;
  localparam logic [31:0] C_XADR_PC  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, exc, irq, imem_ack;
  logic [31:0] redirect_pc, imem_rdata;
  wire         imem_req, fetch_valid;
  wire  [31:0] imem_addr, Instruction, PC, PC_plus_4;

  if_fetch_unit #(
    .RESET_PC(C_RESET_PC),
    .ILLOP_PC(C_ILLOP_PC),
    .XADR_PC (C_XADR_PC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .exc        (exc),
    .irq        (irq),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .Instruction(Instruction),
    .PC         (PC),
    .PC_plus_4  (PC_plus_4),
    .fetch_valid(fetch_valid)
  );

  always #5 clk = ~clk;

  // Staged stimulus, applied just after each rising edge.
  logic        s_reset, s_stall, s_redirect, s_exc, s_irq;
  logic [31:0] s_rpc;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          force_lat;        // -1 selects random latency 0..3
  bit          outst;
  int          wcnt;
  logic [31:0] lat_addr;
  logic [31:0] exp_pc;
  int          idle;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] inc4(input logic [31:0] p);
`ifdef KERNEL_BIT_KEEP_EN
    return {p[31], p[30:0] + 31'd4};
`else
    return p + 32'd4;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: the stream of delivered instructions must follow
  // sequential +4 order, restart at the latest redirect target, repeat while
  // stalled, and never stay empty for long.
  task automatic model();
    logic        irq_eff;
    logic        take;
    logic [31:0] tgt;
    if (reset) begin
      chk("reset_req", {31'b0, imem_req}, 32'd0);
      chk("reset_valid", {31'b0, fetch_valid}, 32'd0);
      exp_pc = C_RESET_PC;
      idle   = 0;
    end else begin
      irq_eff = irq;
`ifdef KERNEL_BIT_KEEP_EN
      if (exp_pc[31]) irq_eff = 1'b0;
`endif
      take = exc | irq_eff | redirect;
      tgt  = exc ? C_ILLOP_PC : (irq_eff ? C_XADR_PC : redirect_pc);
      if (take) chk("take_kills_valid", {31'b0, fetch_valid}, 32'd0);
      if (fetch_valid === 1'b1) begin
        chk("model_pc", PC, exp_pc);
        chk("model_instr", Instruction, memw(exp_pc));
        chk("model_pc4", PC_plus_4, inc4(exp_pc));
      end
      if (fetch_valid === 1'b1 || take) idle = 0;
      else idle++;
      chk("liveness", {31'b0, (idle > 9)}, 32'd0);
      if (take) exp_pc = tgt;
      else if (fetch_valid === 1'b1 && !stall) exp_pc = inc4(exp_pc);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    reset       = s_reset;
    stall       = s_stall;
    redirect    = s_redirect;
    redirect_pc = s_rpc;
    exc         = s_exc;
    irq         = s_irq;
    #1;
    if (imem_req === 1'b1) begin
      if (!outst) begin
        outst    = 1'b1;
        lat_addr = imem_addr;
        wcnt     = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
      end else begin
        chk("addr_stable", imem_addr, lat_addr);
      end
      if (wcnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = memw(imem_addr);
        outst      = 1'b0;
      end else begin
        wcnt--;
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
      end
    end else begin
      if (outst && !reset) chk("req_held", {31'b0, imem_req}, 32'd1);
      outst      = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
    end
    @(negedge clk);
    model();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; exc = 1'b0; irq = 1'b0;
    redirect_pc = '0; imem_ack = 1'b0; imem_rdata = '0;
    s_reset = 1'b1; s_stall = 1'b0; s_redirect = 1'b0; s_exc = 1'b0; s_irq = 1'b0;
    s_rpc = '0; force_lat = 0; outst = 1'b0; wcnt = 0; lat_addr = '0;
    exp_pc = C_RESET_PC; idle = 0;

    // Reset
    cyc();
    cyc();
    s_reset = 1'b0;

    // Zero-wait streaming from the reset vector
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t1_addr", imem_addr, C_RESET_PC + 32'(4 * i));
      chk("t1_valid", {31'b0, fetch_valid}, 32'd1);
      chk("t1_instr", Instruction, memw(C_RESET_PC + 32'(4 * i)));
    end

    // Three wait states
    force_lat = 3;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_wait_valid", {31'b0, fetch_valid}, 32'd0);
      chk("t2_addr_hold", imem_addr, 32'h8000_000C);
    end
    cyc();
    chk("t2_ack_valid", {31'b0, fetch_valid}, 32'd1);
    chk("t2_ack_instr", Instruction, memw(32'h8000_000C));
    force_lat = 0;
    cyc();
    chk("t2_next_addr", imem_addr, 32'h8000_0010);

    // Stall on the ack cycle and one more cycle
    s_stall = 1'b1;
    cyc();
    chk("t3_ack_pc", PC, 32'h8000_0014);
    cyc();
    chk("t3_hold_req", {31'b0, imem_req}, 32'd0);
    chk("t3_hold_instr", Instruction, memw(32'h8000_0014));
    chk("t3_hold_pc", PC, 32'h8000_0014);
    s_stall = 1'b0;
    cyc();
    chk("t3_release_valid", {31'b0, fetch_valid}, 32'd1);
    cyc();
    chk("t3_next_addr", imem_addr, 32'h8000_0018);

    // Redirect while a request is in flight
    force_lat = 3;
    s_redirect = 1'b1; s_rpc = 32'h0000_0040;
    cyc();
    chk("t4_redir_valid", {31'b0, fetch_valid}, 32'd0);
    chk("t4_redir_addr", imem_addr, 32'h8000_001C);
    s_redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t4_discard_valid", {31'b0, fetch_valid}, 32'd0);
      chk("t4_discard_addr", imem_addr, 32'h8000_001C);
    end
    force_lat = 0;
    cyc();
    chk("t4_target_addr", imem_addr, 32'h0000_0040);
    chk("t4_target_instr", Instruction, memw(32'h0000_0040));

    // exc beats redirect; exc during HOLD drops the buffered word
    s_redirect = 1'b1; s_rpc = 32'h0000_0100; s_exc = 1'b1;
    cyc();
    chk("t5_both_valid", {31'b0, fetch_valid}, 32'd0);
    s_redirect = 1'b0; s_exc = 1'b0;
    cyc();
    chk("t5_exc_addr", imem_addr, C_ILLOP_PC);
    s_stall = 1'b1;
    cyc();
    s_exc = 1'b1;
    cyc();
    chk("t5_hold_exc_valid", {31'b0, fetch_valid}, 32'd0);
    chk("t5_hold_exc_req", {31'b0, imem_req}, 32'd0);
    s_exc = 1'b0; s_stall = 1'b0;
    cyc();
    chk("t5_vector_addr", imem_addr, C_ILLOP_PC);

    // Top-of-memory wrap and irq masking
    s_redirect = 1'b1; s_rpc = 32'hFFFF_FFFC;
    cyc();
    s_redirect = 1'b0; s_irq = 1'b1;
    cyc();
    chk("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
`ifdef KERNEL_BIT_KEEP_EN
    chk("t6_pc4", PC_plus_4, 32'h8000_0000);
    chk("t6_irq_valid", {31'b0, fetch_valid}, 32'd1);
`else
    chk("t6_pc4", PC_plus_4, 32'h0000_0000);
    chk("t6_irq_valid", {31'b0, fetch_valid}, 32'd0);
`endif
    s_irq = 1'b0;
    cyc();
`ifdef KERNEL_BIT_KEEP_EN
    chk("t6_next_addr", imem_addr, 32'h8000_0000);
`else
    chk("t6_next_addr", imem_addr, C_XADR_PC);
`endif

    // Randomized traffic checked by the reference model
    force_lat = -1;
    for (int i = 0; i < 600; i++) begin
      s_reset    = ($urandom_range(0, 99) == 0);
      s_stall    = ($urandom_range(0, 3) == 0);
      s_redirect = ($urandom_range(0, 9) == 0);
      s_rpc      = {16'h0000, 14'($urandom), 2'b00};
      s_exc      = ($urandom_range(0, 29) == 0);
`ifdef KERNEL_BIT_KEEP_EN
      s_irq      = 1'b0;
`else
      s_irq      = ($urandom_range(0, 29) == 0);
`endif
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
